// File: rtl/adc_widen_avg_pkg.sv
// Shared constants for the ADC widening averager; LSB_POS_DEF is shared with the DAC slicer
// so a sample passed straight through and then sliced comes back unchanged.
package adc_widen_avg_pkg;

  localparam int unsigned ADC_W        = 14;
  localparam int unsigned WOUT_DEF     = 64;
  localparam int unsigned LSB_POS_DEF  = 18;
  localparam int unsigned MAX_LOG2_DEF = 10;
  localparam int unsigned LOG2_PORT_W  = 4;

  localparam logic [ADC_W-1:0] ADC_MAX = 14'h1FFF;
  localparam logic [ADC_W-1:0] ADC_MIN = 14'h2000;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

endpackage : adc_widen_avg_pkg

// File: rtl/adc_widen_avg_if.sv
// Sample-in / averaged-result-out bundle for adc_widen_avg; names follow the block's port view.
interface adc_widen_avg_if
  import adc_widen_avg_pkg::*;
#(
  parameter int unsigned WIN  = ADC_W,
  parameter int unsigned WOUT = WOUT_DEF
);

  logic [WIN-1:0]         sig_i;
  logic                   sig_valid_i;
  logic [LOG2_PORT_W-1:0] avg_log2_i;
  logic                   clear_i;
  logic [WOUT-1:0]        sig_o;
  logic                   sig_valid_o;
  logic                   clip_o;

  // Source side (ADC capture / testbench).
  modport master (
    output sig_i, sig_valid_i, avg_log2_i, clear_i,
    input  sig_o, sig_valid_o, clip_o
  );

  // Averager side.
  modport slave (
    input  sig_i, sig_valid_i, avg_log2_i, clear_i,
    output sig_o, sig_valid_o, clip_o
  );

endinterface : adc_widen_avg_if

// File: rtl/adc_widen_avg_rail_detect.sv
// Combinational rail detector: flags the most-positive or most-negative two's-complement code.
module adc_rail_detect #(
  parameter int unsigned WIN = 14
) (
  input  logic [WIN-1:0] sample_i,
  output logic           hit_o_c
);

  localparam logic [WIN-1:0] RAIL_MAX = {1'b0, {(WIN-1){1'b1}}};
  localparam logic [WIN-1:0] RAIL_MIN = {1'b1, {(WIN-1){1'b0}}};

  assign hit_o_c = (sample_i == RAIL_MAX) || (sample_i == RAIL_MIN);

endmodule : adc_rail_detect

// File: rtl/adc_widen_avg.sv
// Boxcar average of 2^L signed ADC samples, emitted as an exact mean aligned so the
// input integer LSB lands at LSB_POS; flags windows that contained a rail code.
module adc_widen_avg
  import adc_widen_avg_pkg::*;
#(
  parameter int unsigned WIN      = ADC_W,
  parameter int unsigned WOUT     = WOUT_DEF,
  parameter int unsigned LSB_POS  = LSB_POS_DEF,
  parameter int unsigned MAX_LOG2 = MAX_LOG2_DEF
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  adc_widen_avg_if.slave  bus
);

  localparam int unsigned ACC_W = WIN + MAX_LOG2;
  localparam int unsigned CNT_W = MAX_LOG2;
  localparam int unsigned SH_W  = $clog2(WOUT);

  if (WOUT < WIN + LSB_POS) begin : g_bad_wout
    $error("adc_widen_avg: WOUT must be >= WIN+LSB_POS");
  end
  if (LSB_POS < MAX_LOG2) begin : g_bad_lsb
    $error("adc_widen_avg: LSB_POS must be >= MAX_LOG2");
  end

  state_t                  state_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [LOG2_PORT_W-1:0]  lg_q;
  logic                    clip_q;
  logic [WOUT-1:0]         sig_o_q;
  logic                    sig_valid_o_q;
  logic                    clip_o_q;

  logic                    rail_hit;
  logic                    start;
  logic [LOG2_PORT_W-1:0]  lg_req;
  logic [LOG2_PORT_W-1:0]  lg_eff;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0]        cnt_cur;
  logic [CNT_W:0]          win_len;
  logic                    last;
  logic                    clip_d;
  logic [SH_W-1:0]         shamt;
  logic [WOUT-1:0]         sig_o_d;

  adc_rail_detect #(.WIN(WIN)) u_rail (
    .sample_i (bus.sig_i),
    .hit_o_c  (rail_hit)
  );

  // A window opens on the first accepted sample in IDLE; L is frozen from that sample on.
  always_comb begin
    start      = (state_q == ST_IDLE) && bus.sig_valid_i && !bus.clear_i;
    lg_req     = (bus.avg_log2_i > LOG2_PORT_W'(MAX_LOG2)) ? LOG2_PORT_W'(MAX_LOG2)
                                                           : bus.avg_log2_i;
    lg_eff     = start ? lg_req : lg_q;
    sample_ext = ACC_W'($signed(bus.sig_i));
    acc_d      = (start ? '0 : acc_q) + sample_ext;
    cnt_cur    = start ? '0 : cnt_q;
    clip_d     = (start ? 1'b0 : clip_q) | rail_hit;
    win_len    = (CNT_W+1)'(1) << lg_eff;
    last       = ({1'b0, cnt_cur} == (win_len - (CNT_W+1)'(1)));
    shamt      = SH_W'(LSB_POS) - SH_W'(lg_eff);
    sig_o_d    = WOUT'(acc_d) << shamt;
  end

  // Window FSM, accumulator and registered result.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= ST_IDLE;
      acc_q         <= '0;
      cnt_q         <= '0;
      lg_q          <= '0;
      clip_q        <= 1'b0;
      sig_o_q       <= '0;
      sig_valid_o_q <= 1'b0;
      clip_o_q      <= 1'b0;
    end else begin
      sig_valid_o_q <= 1'b0;
      if (bus.clear_i) begin
        state_q <= ST_IDLE;
        acc_q   <= '0;
        cnt_q   <= '0;
        clip_q  <= 1'b0;
      end else if (bus.sig_valid_i) begin
        if (start) begin
          lg_q <= lg_req;
        end
        if (last) begin
          state_q       <= ST_IDLE;
          acc_q         <= '0;
          cnt_q         <= '0;
          clip_q        <= 1'b0;
          sig_o_q       <= sig_o_d;
          sig_valid_o_q <= 1'b1;
          clip_o_q      <= clip_d;
        end else begin
          state_q <= ST_ACCUM;
          acc_q   <= acc_d;
          cnt_q   <= cnt_cur + CNT_W'(1);
          clip_q  <= clip_d;
        end
      end
    end
  end

  assign bus.sig_o       = sig_o_q;
  assign bus.sig_valid_o = sig_valid_o_q;
  assign bus.clip_o      = clip_o_q;

endmodule : adc_widen_avg

// File: tb/tb_adc_widen_avg.sv
// Directed bench for adc_widen_avg: arithmetic reference model checked every cycle,
// plus hand-computed literal results for each scenario.
module tb_adc_widen_avg;
  import adc_widen_avg_pkg::*;

  localparam int LSB = 18;
  localparam int MAXL = 10;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  adc_widen_avg_if #(.WIN(14), .WOUT(64)) bus ();

  adc_widen_avg dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collect samples, mean = sum * 2^(LSB-L) once 2^L samples are in.
  longint m_sum;
  int     m_n;
  int     m_l;
  bit     m_open;
  bit     m_clip_acc;
  bit     m_valid;
  longint m_sig;
  bit     m_clip;

  always @(posedge clk or negedge rstn) begin : model
    longint s;
    int     n;
    int     l;
    bit     o;
    bit     c;
    bit     v;
    longint so;
    bit     co;
    if (!rstn) begin
      m_sum <= 0; m_n <= 0; m_l <= 0; m_open <= 1'b0; m_clip_acc <= 1'b0;
      m_valid <= 1'b0; m_sig <= 0; m_clip <= 1'b0;
    end else begin
      s = m_sum; n = m_n; l = m_l; o = m_open; c = m_clip_acc;
      v = 1'b0; so = m_sig; co = m_clip;
      if (bus.clear_i) begin
        o = 1'b0;
      end else if (bus.sig_valid_i) begin
        if (!o) begin
          o = 1'b1;
          l = (int'(bus.avg_log2_i) > MAXL) ? MAXL : int'(bus.avg_log2_i);
          s = 0; n = 0; c = 1'b0;
        end
        s = s + longint'($signed(bus.sig_i));
        n = n + 1;
        c = c | (bus.sig_i == ADC_MAX) | (bus.sig_i == ADC_MIN);
        if (n == (1 << l)) begin
          v  = 1'b1;
          so = s * (longint'(1) << (LSB - l));
          co = c;
          o  = 1'b0;
        end
      end
      m_sum <= s; m_n <= n; m_l <= l; m_open <= o; m_clip_acc <= c;
      m_valid <= v; m_sig <= so; m_clip <= co;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_valid", 64'(bus.sig_valid_o), 64'(m_valid));
    chk("cyc_sig",   bus.sig_o,            64'(m_sig));
    chk("cyc_clip",  64'(bus.clip_o),      64'(m_clip));
  end

  task automatic step(input logic v, input logic [13:0] s, input logic clr);
    bus.sig_valid_i = v;
    bus.sig_i       = s;
    bus.clear_i     = clr;
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [63:0] exp_sig, input logic exp_clip);
    chk({name, "_valid"}, 64'(bus.sig_valid_o), 64'd1);
    chk({name, "_sig"},   bus.sig_o,            exp_sig);
    chk({name, "_clip"},  64'(bus.clip_o),      64'(exp_clip));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn = 1'b0;
    bus.sig_i = '0;
    bus.sig_valid_i = 1'b0;
    bus.avg_log2_i = '0;
    bus.clear_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sig",   bus.sig_o,            64'd0);
    chk("rst_valid", 64'(bus.sig_valid_o), 64'd0);
    chk("rst_clip",  64'(bus.clip_o),      64'd0);
    rstn = 1'b1;
    step(1'b0, 14'h0, 1'b0);

    // L=0 passthrough of both rails and a small code
    bus.avg_log2_i = 4'd0;
    step(1'b1, 14'h1FFF, 1'b0);
    lit("t1", 64'h0000_0000_7FFC_0000, 1'b1);
    step(1'b1, 14'h2000, 1'b0);
    lit("t2a", 64'hFFFF_FFFF_8000_0000, 1'b1);
    step(1'b1, 14'h0001, 1'b0);
    lit("t2b", 64'h0000_0000_0004_0000, 1'b0);
    step(1'b0, 14'h0, 1'b0);

    // L=2 with gaps between samples
    bus.avg_log2_i = 4'd2;
    step(1'b1, 14'd1, 1'b0);
    step(1'b0, 14'd0, 1'b0);
    step(1'b1, 14'd2, 1'b0);
    step(1'b0, 14'd0, 1'b0);
    step(1'b0, 14'd0, 1'b0);
    step(1'b1, 14'd3, 1'b0);
    step(1'b0, 14'd0, 1'b0);
    step(1'b1, 14'd4, 1'b0);
    lit("t3", 64'h0000_0000_000A_0000, 1'b0);
    step(1'b0, 14'd0, 1'b0);
    chk("t3_single", 64'(bus.sig_valid_o), 64'd0);

    // clear with a simultaneous sample drops the partial window and the sample
    step(1'b1, 14'd5, 1'b0);
    step(1'b1, 14'd5, 1'b0);
    step(1'b1, 14'd9, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 14'd1, 1'b0);
    lit("t4", 64'h0000_0000_0004_0000, 1'b0);

    // sticky clip inside a window, cleared at the next window start
    step(1'b1, 14'h1FFF, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 14'd0, 1'b0);
    lit("clip_win", 64'h0000_0000_1FFF_0000, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 14'd1, 1'b0);
    lit("clip_clr", 64'h0000_0000_0004_0000, 1'b0);

    // L=1 back-to-back, L change mid-window applies from the third window
    bus.avg_log2_i = 4'd1;
    step(1'b1, 14'h3FFD, 1'b0);
    step(1'b1, 14'h3FFB, 1'b0);
    lit("t5a", 64'hFFFF_FFFF_FFF0_0000, 1'b0);
    step(1'b1, 14'd7, 1'b0);
    bus.avg_log2_i = 4'd3;
    step(1'b1, 14'd7, 1'b0);
    lit("t5b", 64'h0000_0000_001C_0000, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 14'd2, 1'b0);
    lit("t5c", 64'h0000_0000_0008_0000, 1'b0);

    // L request above the maximum clamps to 10; reset mid-window discards it
    bus.avg_log2_i = 4'd15;
    for (int i = 0; i < 500; i++) step(1'b1, 14'd3, 1'b0);
    bus.sig_valid_i = 1'b0;
    #7;
    rstn = 1'b0;
    #1;
    chk("t6_rst_sig",   bus.sig_o,            64'd0);
    chk("t6_rst_valid", 64'(bus.sig_valid_o), 64'd0);
    chk("t6_rst_clip",  64'(bus.clip_o),      64'd0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 1024; i++) step(1'b1, 14'd3, 1'b0);
    lit("t6", 64'h0000_0000_000C_0000, 1'b0);
    step(1'b0, 14'd0, 1'b0);
    step(1'b0, 14'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_adc_widen_avg
